// File: rtl/cdc_pkg.sv
// Shared types and elaboration helpers for the chunked word sender.
package cdc_pkg;

    // Sender FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        STROBE   = 2'd2,
        WAIT_ACK = 2'd3
    } state_e;

    // Number of link chunks per word.
    function automatic int calc_nch(input int word_w, input int chunk_w);
        return word_w / chunk_w;
    endfunction

    // Width of the chunk index; never narrower than one bit.
    function automatic int calc_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // True when a word splits into a whole number of chunks.
    function automatic bit split_ok(input int word_w, input int chunk_w);
        return (chunk_w > 0) && (word_w >= chunk_w) && ((word_w % chunk_w) == 0);
    endfunction

endpackage

// File: rtl/cdc_ack_watchdog.sv
// Ack watchdog: loadable up-counter that saturates at TIMEOUT_CYC and
// pulses tc on the enabled cycle that reaches the terminal count.
module cdc_ack_watchdog #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TERM      = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] TERM_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear loads zero, otherwise count enabled cycles up to TERM.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TERM)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Terminal-count pulse: the enabled cycle in which the count reaches TERM.
    assign tc = en && !clr && (count_q == TERM_LAST);

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cdc_word_sender.sv
// Source-side driver for the clk1 handshake link: splits each wide word into
// CHUNK_W chunks (LSB first), strobes one chunk per link round-trip, and
// aborts the word if the link never returns ready.
module cdc_word_sender
    import cdc_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int CHUNK_W     = 8,
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_in_en,
    output logic               word_in_ready,
    output logic [CHUNK_W-1:0] link_data,
    output logic               link_en,
    input  logic               link_ready,
    output logic               busy,
    output logic               word_done,
    output logic               err_timeout,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   sent_cnt
);

    localparam int NCH   = calc_nch(WORD_W, CHUNK_W);
    localparam int IDX_W = calc_idx_w(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    if (!split_ok(WORD_W, CHUNK_W)) begin : g_bad_split
        $error("cdc_word_sender: WORD_W must be a positive multiple of CHUNK_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("cdc_word_sender: TIMEOUT_CYC must be at least 1");
    end

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   chunk_idx_q, chunk_idx_d;
    logic [CHUNK_W-1:0] link_data_q, link_data_d;
    logic               link_en_q, link_en_d;
    logic               word_in_ready_q, word_in_ready_d;
    logic               busy_q, busy_d;
    logic               word_done_q, word_done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
    logic               wd_tc;

    // Watchdog is cleared in STROBE and counts only while waiting for the ack.
    cdc_ack_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clr(state_q == STROBE),
        .en (state_q == WAIT_ACK),
        .tc (wd_tc)
    );

    // Next-state and registered-output logic for the sender FSM.
    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        chunk_idx_d     = chunk_idx_q;
        link_data_d     = link_data_q;
        link_en_d       = 1'b0;
        word_in_ready_d = word_in_ready_q;
        busy_d          = busy_q;
        word_done_d     = 1'b0;
        // A new timeout below overrides the clear, so set wins.
        err_d           = err_q && !err_clr;
        sent_cnt_d      = sent_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (word_in_en) begin
                    word_d          = word_in;
                    chunk_idx_d     = '0;
                    busy_d          = 1'b1;
                    word_in_ready_d = 1'b0;
                    state_d         = SEND;
                end
            end
            SEND: begin
                if (link_ready) begin
                    link_data_d = word_q[int'(chunk_idx_q) * CHUNK_W +: CHUNK_W];
                    link_en_d   = 1'b1;
                    state_d     = STROBE;
                end
            end
            STROBE: begin
                // The link still shows ready during the strobe cycle, so ignore it here.
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (link_ready) begin
                    if (chunk_idx_q == LAST_IDX) begin
                        word_done_d     = 1'b1;
                        sent_cnt_d      = sent_cnt_q + CNT_W'(1);
                        busy_d          = 1'b0;
                        word_in_ready_d = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        chunk_idx_d = chunk_idx_q + IDX_W'(1);
                        state_d     = SEND;
                    end
                end else if (wd_tc) begin
                    err_d           = 1'b1;
                    busy_d          = 1'b0;
                    word_in_ready_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            chunk_idx_q     <= '0;
            link_data_q     <= '0;
            link_en_q       <= 1'b0;
            word_in_ready_q <= 1'b1;
            busy_q          <= 1'b0;
            word_done_q     <= 1'b0;
            err_q           <= 1'b0;
            sent_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            chunk_idx_q     <= chunk_idx_d;
            link_data_q     <= link_data_d;
            link_en_q       <= link_en_d;
            word_in_ready_q <= word_in_ready_d;
            busy_q          <= busy_d;
            word_done_q     <= word_done_d;
            err_q           <= err_d;
            sent_cnt_q      <= sent_cnt_d;
        end
    end

    // Word holding register; only read after it has been loaded in IDLE.
    always_ff @(posedge clk) begin
        // NOTE: datapath storage is deliberately not reset; it is always written before use.
        word_q <= word_d;
    end

    assign word_in_ready = word_in_ready_q;
    assign link_data     = link_data_q;
    assign link_en       = link_en_q;
    assign busy          = busy_q;
    assign word_done     = word_done_q;
    assign err_timeout   = err_q;
    assign sent_cnt      = sent_cnt_q;

endmodule

// File: tb/tb_cdc_word_sender.sv
// Directed self-checking bench for cdc_word_sender with a behavioural link model.
module tb_cdc_word_sender;

    localparam int WORD_W      = 32;
    localparam int CHUNK_W     = 8;
    localparam int TIMEOUT_CYC = 15;
    localparam int CNT_W       = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [WORD_W-1:0]  word_in;
    logic               word_in_en;
    logic               word_in_ready;
    logic [CHUNK_W-1:0] link_data;
    logic               link_en;
    logic               link_ready;
    logic               busy;
    logic               word_done;
    logic               err_timeout;
    logic               err_clr;
    logic [CNT_W-1:0]   sent_cnt;

    cdc_word_sender #(
        .WORD_W(WORD_W), .CHUNK_W(CHUNK_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_in_en(word_in_en),
        .word_in_ready(word_in_ready), .link_data(link_data), .link_en(link_en),
        .link_ready(link_ready), .busy(busy), .word_done(word_done),
        .err_timeout(err_timeout), .err_clr(err_clr), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Link model controls and observations.
    int ack_delay  = 3;
    int stall_at   = 0;
    int strobe_cnt = 0;
    int done_cnt   = 0;
    int min_gap    = 1000;
    int last_cyc   = -1000;
    int cyc        = 0;
    int low_left   = 0;
    bit drop_next  = 1'b0;
    bit pend_stall = 1'b0;
    bit stalled    = 1'b0;
    logic [CHUNK_W-1:0] strobes[$];
    logic [CNT_W-1:0]   cnt_log[$];
    logic [WORD_W-1:0]  exp_words[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Link responder: ready stays high through the strobe cycle, then drops
    // for ack_delay cycles, or until released when the stall point is hit.
    initial begin
        link_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (word_done) begin
                done_cnt++;
                cnt_log.push_back(sent_cnt);
            end
            if (link_en) begin
                if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                last_cyc = cyc;
                strobes.push_back(link_data);
                strobe_cnt++;
                drop_next  = 1'b1;
                pend_stall = (strobe_cnt == stall_at);
            end else if (drop_next) begin
                drop_next = 1'b0;
                if (pend_stall) begin
                    link_ready = 1'b0;
                    stalled    = 1'b1;
                end else if (ack_delay > 0) begin
                    link_ready = 1'b0;
                    low_left   = ack_delay;
                end
            end else if (stalled) begin
                if (stall_at == 0) begin
                    stalled    = 1'b0;
                    link_ready = 1'b1;
                end
            end else if (low_left > 0) begin
                low_left--;
                if (low_left == 0) link_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Present a word with valid held until the block takes it.
    task automatic push(input logic [WORD_W-1:0] w);
        bit taken = 1'b0;
        word_in    = w;
        word_in_en = 1'b1;
        exp_words.push_back(w);
        for (int i = 0; i < 1000 && !taken; i++) begin
            if (word_in_ready === 1'b1) taken = 1'b1;
            tick();
        end
        check("word_accepted", taken, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy !== 1'b0; i++) tick();
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_strobes(input int target);
        for (int i = 0; i < 1000 && strobe_cnt < target; i++) tick();
        check("strobe_reached", strobe_cnt, target);
    endtask

    task automatic check_strobes(input string tag);
        logic [CHUNK_W-1:0] exp_b[$];
        logic [WORD_W-1:0]  w;
        foreach (exp_words[k]) begin
            w = exp_words[k];
            for (int i = 0; i < WORD_W / CHUNK_W; i++) exp_b.push_back(w[i*CHUNK_W +: CHUNK_W]);
        end
        check({tag, "_strobe_count"}, strobes.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < strobes.size(); i++)
            check($sformatf("%s_chunk%0d", tag, i), strobes[i], exp_b[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_word_in_ready"}, word_in_ready, 1);
        check({tag, "_link_data"}, link_data, 0);
        check({tag, "_link_en"}, link_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_done"}, word_done, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_sent_cnt"}, sent_cnt, 0);
    endtask

    task automatic start_test();
        strobes.delete();
        exp_words.delete();
    endtask

    initial begin
        int base;
        int d0;
        int n;

        rst        = 1'b1;
        word_in    = '0;
        word_in_en = 1'b0;
        err_clr    = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check("post_reset_link_en", link_en, 0);

        // Basic word, ack after 3 cycles, plus accept-to-strobe latency.
        start_test();
        ack_delay = 3;
        push(32'hA1B2C3D4);
        word_in_en = 1'b0;
        check("t1_send_link_en", link_en, 0);
        check("t1_send_busy", busy, 1);
        check("t1_send_ready", word_in_ready, 0);
        tick();
        check("t1_first_strobe", link_en, 1);
        check("t1_first_data", link_data, 8'hD4);
        wait_idle("t1");
        check_strobes("t1");
        check("t1_done_cnt", done_cnt, 1);
        check("t1_sent_cnt", sent_cnt, 1);

        // Immediate ready after STROBE: strobes exactly 3 cycles apart.
        start_test();
        ack_delay = 0;
        min_gap   = 1000;
        push(32'h55667788);
        word_in_en = 1'b0;
        wait_idle("t2");
        check_strobes("t2");
        check("t2_min_gap", min_gap, 3);
        check("t2_sent_cnt", sent_cnt, 2);
        tick();
        check("t2_done_single", word_done, 0);

        // Ready returns on the very cycle the watchdog expires: ready wins.
        start_test();
        ack_delay = TIMEOUT_CYC - 1;
        push(32'h0F1E2D3C);
        word_in_en = 1'b0;
        wait_idle("t2b");
        check_strobes("t2b");
        check("t2b_no_err", err_timeout, 0);
        check("t2b_sent_cnt", sent_cnt, 3);

        // Link stalls after the second chunk: abort after 15 WAIT_ACK cycles.
        start_test();
        ack_delay = 3;
        d0        = done_cnt;
        stall_at  = strobe_cnt + 2;
        push(32'hDEADBEEF);
        word_in_en = 1'b0;
        wait_strobes(stall_at);
        n = 0;
        for (int i = 0; i < 100 && err_timeout !== 1'b1; i++) begin
            tick();
            n++;
        end
        check("t3_timeout_cycles", n, TIMEOUT_CYC + 1);
        check("t3_err", err_timeout, 1);
        check("t3_busy", busy, 0);
        check("t3_ready", word_in_ready, 1);
        check("t3_sent_cnt", sent_cnt, 3);
        check("t3_no_done", done_cnt - d0, 0);
        exp_words.delete();
        exp_words.push_back(32'h0000BEEF);
        strobes.push_back(8'h00);
        strobes.push_back(8'h00);
        check_strobes("t3_partial");
        stall_at = 0;
        repeat (2) tick();
        start_test();
        push(32'h11223344);
        word_in_en = 1'b0;
        wait_idle("t3_next");
        check_strobes("t3_next");
        check("t3_next_sent_wrap", sent_cnt, 0);
        check("t3_err_sticky", err_timeout, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_cleared", err_timeout, 0);

        // Timeout while err_clr is held: the set wins on the abort edge.
        start_test();
        err_clr  = 1'b1;
        stall_at = strobe_cnt + 1;
        push(32'hCAFEF00D);
        word_in_en = 1'b0;
        wait_idle("t3b");
        check("t3b_set_wins", err_timeout, 1);
        tick();
        check("t3b_clr_after", err_timeout, 0);
        err_clr  = 1'b0;
        stall_at = 0;
        repeat (2) tick();
        check("t3b_sent_cnt", sent_cnt, 0);

        // Valid held continuously across four words.
        start_test();
        ack_delay = 1;
        d0        = done_cnt;
        push(32'h01020304);
        push(32'h05060708);
        push(32'h090A0B0C);
        push(32'h0D0E0F10);
        word_in_en = 1'b0;
        wait_idle("t4");
        check_strobes("t4");
        check("t4_done_cnt", done_cnt - d0, 4);
        check("t4_sent_cnt", sent_cnt, 0);

        // Reset during the third chunk's WAIT_ACK.
        start_test();
        ack_delay = 3;
        base      = strobe_cnt;
        d0        = done_cnt;
        push(32'h89ABCDEF);
        word_in_en = 1'b0;
        wait_strobes(base + 3);
        tick();
        rst = 1'b1;
        tick();
        check_reset_vals("t5_reset");
        rst = 1'b0;
        tick();
        check("t5_no_strobe_after_rst", link_en, 0);
        repeat (20) tick();
        check("t5_no_stale_strobes", strobe_cnt - base, 3);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle_ready", word_in_ready, 1);

        // Counter wrap with CNT_W=2 over five words.
        cnt_log.delete();
        ack_delay = 0;
        for (int k = 0; k < 5; k++) begin
            push(32'h10203040 + WORD_W'(k));
            word_in_en = 1'b0;
            wait_idle("t6");
        end
        check("t6_log_size", cnt_log.size(), 5);
        for (int k = 0; k < 5 && k < cnt_log.size(); k++)
            check($sformatf("t6_sent_cnt%0d", k), cnt_log[k], (k + 1) % 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
